// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Boot-time program loader. Receives a framed little-endian byte stream,
// assembles 32-bit instruction words and writes them into the instruction
// memory through its preload port at consecutive word addresses. The core is
// held in reset until the whole image has been written and its XOR checksum
// has been verified.
//
// Frame: 4-byte word count N (LE), 4*N data bytes (each word LE), 1 checksum
// byte equal to the XOR of every preceding frame byte.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start         one-cycle pulse arming a new load (ignored while busy)
//   s_valid       byte stream valid
//   s_data        byte stream data
//   s_ready       byte stream ready (high in HDR, DATA, CSUM)
//   preload_en    one-cycle instruction-memory write strobe
//   preload_addr  0-based word address of the write
//   preload_data  instruction word of the write
//   core_rst_n    core reset, active low; released only after a verified load
//   busy          load in progress
//   done          image loaded and verified (sticky until next start)
//   err           load failed (sticky until next start)
// -----------------------------------------------------------------------------
package instr_mem_pkg;
    localparam int INSTR_MEM_ADDR_WIDTH = 10;
    localparam int INSTR_MEM_DATA_WIDTH = 32;
endpackage

module instr_mem_loader #(
    parameter int ADDR_WIDTH = instr_mem_pkg::INSTR_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = instr_mem_pkg::INSTR_MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  preload_en,
    output logic [ADDR_WIDTH-1:0] preload_addr,
    output logic [DATA_WIDTH-1:0] preload_data,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Largest image that fits: 2^ADDR_WIDTH words, compared in 33 bits so the
    // full 32-bit count can never alias.
    localparam logic [32:0]         MAX_WORDS = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state, state_next;
    logic [31:0]         count;
    logic [1:0]          byte_cnt;
    logic [ADDR_WIDTH:0] word_idx;   // one extra bit: N = 2^ADDR_WIDTH is legal
    logic [7:0]          xor_acc;
    logic [23:0]         word_buf;   // lanes 0..2; lane 3 comes straight from s_data

    logic                xfer;
    logic [31:0]         hdr_count;
    logic                last_word;

    assign xfer      = s_valid && s_ready;
    // Complete count as it will be once the 4th header byte lands.
    assign hdr_count = {s_data, count[23:0]};
    assign last_word = (32'(word_idx) + 32'd1) == count;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_next unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                if (xfer && byte_cnt == 2'd3) begin
                    if (hdr_count == 32'd0)                 state_next = CSUM;
                    else if ({1'b0, hdr_count} > MAX_WORDS) state_next = ERR;
                    else                                    state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && byte_cnt == 2'd3 && last_word) state_next = CSUM;
            end
            CSUM: begin
                if (xfer) state_next = (s_data == xor_acc) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the state register.
    assign s_ready    = (state == HDR) || (state == DATA) || (state == CSUM);
    assign busy       = s_ready;
    assign done       = (state == DONE);
    assign err        = (state == ERR);
    assign core_rst_n = (state == DONE);

    // Datapath: count capture, word assembly, running checksum, preload port
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            xor_acc      <= '0;
            word_buf     <= '0;
            preload_en   <= 1'b0;
            preload_addr <= '0;
            preload_data <= '0;
        end else begin
            preload_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        count    <= '0;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        xor_acc  <= '0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        xor_acc  <= xor_acc ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    count[7:0]   <= s_data;
                            2'd1:    count[15:8]  <= s_data;
                            2'd2:    count[23:16] <= s_data;
                            default: count[31:24] <= s_data;
                        endcase
                    end
                end
                DATA: begin
                    if (xfer) begin
                        xor_acc  <= xor_acc ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= s_data;
                            2'd1: word_buf[15:8]  <= s_data;
                            2'd2: word_buf[23:16] <= s_data;
                            default: begin
                                preload_data <= {s_data, word_buf};
                                preload_addr <= word_idx[ADDR_WIDTH-1:0];
                                preload_en   <= 1'b1;
                                word_idx     <= word_idx + IDX_ONE;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Self-checking bench for instr_mem_loader. A frame builder produces byte
// streams from word lists; the driver pushes the expected preload writes
// (address, data, cycle) into a scoreboard as each word's last byte transfers,
// and an independent monitor pops and compares on every preload_en. The load
// outcome (done/err/core_rst_n) is predicted from the frame contents.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [31:0]   preload_data;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .preload_en   (preload_en),
        .preload_addr (preload_addr),
        .preload_data (preload_data),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc++;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (preload_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr",  32'(preload_addr), 32'(mon_e.addr));
                check("wr_data",  preload_data, mon_e.data);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Reference frame builder: count LE, words LE, XOR checksum (optionally spoiled).
    function automatic bq_t make_frame(input logic [31:0] n, input wq_t words, input bit corrupt);
        bq_t        f;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) f.push_back(n[8*i +: 8]);
        foreach (words[w]) for (int b = 0; b < 4; b++) f.push_back(words[w][8*b +: 8]);
        foreach (f[i]) x ^= f[i];
        f.push_back(corrupt ? ~x : x);
        return f;
    endfunction

    function automatic logic [7:0] xor_all(input bq_t f);
        logic [7:0] x;
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        return x;
    endfunction

    task automatic check_reset_outputs();
        check("rst_s_ready",      32'(s_ready),      32'd0);
        check("rst_preload_en",   32'(preload_en),   32'd0);
        check("rst_preload_addr", 32'(preload_addr), 32'd0);
        check("rst_preload_data", preload_data,      32'd0);
        check("rst_core_rst_n",   32'(core_rst_n),   32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_done",         32'(done),         32'd0);
        check("rst_err",          32'(err),          32'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_s_ready",    32'(s_ready),    32'd1);
        check("start_busy",       32'(busy),       32'd1);
        check("start_done",       32'(done),       32'd0);
        check("start_err",        32'(err),        32'd0);
        check("start_core_rst_n", 32'(core_rst_n), 32'd0);
    endtask

    // Drive a frame. stop_after >= 0 sends only that many bytes and skips the
    // outcome check. Oversize counts send only the header (the loader stops).
    task automatic run_frame(input bq_t f, input int gap_pct, input bit poke_start, input int stop_after);
        logic [31:0] n;
        int          nw;
        int          limit;
        int          waited;
        bit          sent;
        bit          exp_ok;
        n      = {f[3], f[2], f[1], f[0]};
        nw     = (n > 32'(DEPTH)) ? 0 : int'(n);
        limit  = (n > 32'(DEPTH)) ? 4 : f.size();
        if (stop_after >= 0) limit = stop_after;
        for (int j = 0; j < limit; j++) begin
            sent   = 1'b0;
            waited = 0;
            while (!sent) begin
                @(negedge clk);
                s_valid = ($urandom_range(99) >= gap_pct);
                s_data  = s_valid ? f[j] : 8'($urandom);
                start   = poke_start && ($urandom_range(9) == 0);
                if (s_valid && s_ready) begin
                    sent = 1'b1;
                    if (j >= 4 && j < 4 + 4*nw && ((j - 4) % 4) == 3)
                        sb.push_back('{addr: AW'((j - 4) / 4),
                                       data: {f[j], f[j-1], f[j-2], f[j-3]},
                                       cyc:  cyc + 1});
                end else if (++waited > 50) begin
                    check("stall_timeout", 32'd0, 32'd1);
                    s_valid = 1'b0;
                    start   = 1'b0;
                    return;
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
        if (stop_after < 0) begin
            exp_ok = (n <= 32'(DEPTH)) && (xor_all(f) == 8'h00);
            check("end_done",       32'(done),       32'(exp_ok));
            check("end_err",        32'(err),        32'(!exp_ok));
            check("end_core_rst_n", 32'(core_rst_n), 32'(exp_ok));
            check("end_s_ready",    32'(s_ready),    32'd0);
            check("end_busy",       32'(busy),       32'd0);
            @(negedge clk);
            check("sb_drained", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    bq_t known;
    bq_t bad;
    bq_t f;
    wq_t words;
    wq_t empty_words;

    initial begin
        known = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'hA0, 8'h00, 8'h22};
        bad   = known;
        bad[12] = 8'h23;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Reference N=2 stream, back-to-back
        do_start();
        run_frame(known, 0, 1'b0, -1);

        // Same stream with random valid gaps and stray start pulses
        do_start();
        run_frame(known, 40, 1'b1, -1);

        // Bad checksum: both writes, then err
        do_start();
        run_frame(bad, 0, 1'b0, -1);

        // N = 0
        do_start();
        f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(f, 0, 1'b0, -1);

        // Oversize count, then recovery with a valid frame
        do_start();
        f = make_frame(32'(DEPTH + 1), empty_words, 1'b0);
        run_frame(f, 0, 1'b0, -1);
        do_start();
        run_frame(known, 0, 1'b0, -1);

        // Reset after the 6th byte, then a clean reload
        do_start();
        run_frame(known, 0, 1'b0, 6);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        check("rst_sb_empty", sb.size(), 32'd0);
        sb.delete();
        rst = 1'b0;
        do_start();
        run_frame(known, 0, 1'b0, -1);

        // Randomized frames, including a full-memory image
        for (int t = 0; t < 20; t++) begin
            int n;
            bit corrupt;
            n       = (t == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
            corrupt = (t != 0) && ($urandom_range(3) == 0);
            words.delete();
            for (int w = 0; w < n; w++) words.push_back($urandom);
            f = make_frame(32'(n), words, corrupt);
            do_start();
            run_frame(f, 30, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
